sprite_pose_rom_bank: RTL
=========================

// Module: sprite_pose_rom_bank
// PURPOSE
//  Replaces the per-pose 4096x4 sprite ROMs with one parametrised multi-pose ROM bank per fighter.
//  - Latches the requested pose only at frame start, so poses never tear mid-frame.
//  - Mirrors the sprite horizontally for facing direction.
//  - Flags out-of-box pixels as transparent.
//  - Delivers a palette index with fixed 2-cycle latency.
//  - Sits between the fighter FSM/pixel scanner and the palette/colour mapper.
// PARAMETERS
//  NUM_POSES        10          number of poses stored back to back in the ROM
//  SPRITE_W         64          sprite width in pixels (power of 2)
//  SPRITE_H         64          sprite height in pixels (power of 2)
//  PIX_BITS         4           palette index width
//  COORD_W          10          width of the sprite-local pixel coordinate inputs
//  TRANSPARENT_IDX  0           palette index that means "no pixel"
//  HOLD_FRAMES      6           minimum frames a pose is held (used only with SPRITE_POSE_HOLD_EN)
//  INIT_FILE        "sprite_bank.mif"   ram_init_file for the whole bank
//  localparams:
//    POSE_W = $clog2(NUM_POSES)
//    ADDR_W = $clog2(NUM_POSES*SPRITE_W*SPRITE_H)
// PORTS
//  clock        in   1          system clock; all logic is on posedge
//  reset        in   1          synchronous, active-high reset
//  frame_start  in   1          1-cycle pulse at start of vblank
//  pose_req     in   POSE_W     pose requested by the fighter FSM
//  flip         in   1          1 = mirror horizontally (facing left); sampled with pix_req
//  pix_req      in   1          pixel lookup request this cycle
//  pix_x        in   COORD_W    sprite-local x, unsigned
//  pix_y        in   COORD_W    sprite-local y, unsigned
//  pose_active  out  POSE_W     pose currently used for lookups
//  pix_valid    out  1          pix_index/pix_opaque valid; high 2 cycles after pix_req
//  pix_index    out  PIX_BITS   palette index
//  pix_opaque   out  1          1 when in-box and pix_index != TRANSPARENT_IDX
// BEHAVIOUR
//  - Reset values: pose_active=0, pix_valid=0, pix_index=TRANSPARENT_IDX, pix_opaque=0.
//    Reset also clears the hold counter and all pipeline valid bits.
//    Reset mid-pipeline discards all in-flight requests.
//  - Storage: one array [0:NUM_POSES*SPRITE_W*SPRITE_H-1] of PIX_BITS, read-only, synchronous read.
//  - Pose latch: on frame_start, if pose_req < NUM_POSES, pose_active <= pose_req.
//    If pose_req >= NUM_POSES, the request is ignored and pose_active is kept.
//    A pose_req change without frame_start has no effect.
//  - Stage 0 (cycle after pix_req):
//    - in_box = (pix_x < SPRITE_W) && (pix_y < SPRITE_H).
//    - xm = flip ? SPRITE_W-1-pix_x : pix_x.
//    - addr = pose_active*SPRITE_W*SPRITE_H + pix_y*SPRITE_W + xm, truncated to ADDR_W.
//    - Register addr, in_box and the valid bit.
//  - Stage 1: memory read.
//    - pix_valid <= v0.
//    - pix_index <= in_box ? mem[addr] : TRANSPARENT_IDX.
//    - pix_opaque <= in_box && (mem[addr] != TRANSPARENT_IDX).
//  - Latency is exactly 2 cycles; throughput is 1 request per cycle, with no stalls and no backpressure.
//  - Outputs hold their last value while pix_valid=0.
//  - frame_start coincident with pix_req: the request in that same cycle already uses the new pose.
//    Requests already in stage 0/1 keep the pose they captured.
//  - Out-of-box coordinates never index outside the array; the address is don't-care and the output is forced to transparent.
// CONFIGURATION
//  SPRITE_POSE_HOLD_EN defined:
//    - A hold counter of width $clog2(HOLD_FRAMES+1) decrements on each frame_start while nonzero.
//    - A valid pose_req != pose_active is accepted only when the counter is 0; acceptance loads it with HOLD_FRAMES-1.
//    - A request equal to pose_active never reloads the counter.
//    - Decrement and accept in the same frame_start: accept wins.
//    - HOLD_FRAMES=0 behaves as if the macro were undefined.
//  SPRITE_POSE_HOLD_EN undefined:
//    - No counter exists; every valid pose_req is accepted on frame_start.
// TESTING (test MIF: word = (pose + xm) mod 16, SPRITE_W=SPRITE_H=64, TRANSPARENT_IDX=0)
//  1. Reset, pix_req x=5 y=0 flip=0 -> pix_valid 2 cycles later; index=5, opaque=1.
//     Back-to-back x=0..15 -> 16 consecutive valid outputs with index 0..15.
//  2. pose_req=3 without frame_start, x=5 -> index=5 (pose unchanged).
//     Then pulse frame_start -> pose_active=3; x=5 -> index=8.
//  3. flip=1, pose 0, x=5 -> xm=58, index=10.
//     x=0 -> index=15; x=63 flip=1 -> index=0, opaque=0.
//  4. x=64 or y=70 -> pix_valid=1, index=0, opaque=0.
//     pose_req=12 on frame_start -> pose_active unchanged.
//  5. Assert reset with 2 requests in flight -> no pix_valid in the following 2 cycles; all outputs at reset values.
//  6. With SPRITE_POSE_HOLD_EN and HOLD_FRAMES=6:
//     - Accept pose 4, then request pose 5 on the next 5 frame_starts -> pose_active stays 4.
//     - 6th frame_start -> pose_active=5.
//     Without the macro -> pose 5 is taken on the 1st frame_start.

Source files
------------

// File: rtl/sprite_pose_rom_bank.sv
// Multi-pose sprite ROM bank: frame-synchronous pose latch, horizontal mirroring, and a 2-cycle palette lookup.
// Optional minimum pose hold time is enabled by defining SPRITE_POSE_HOLD_EN.
module sprite_pose_rom_bank #(
    parameter int    NUM_POSES       = 10,
    parameter int    SPRITE_W        = 64,
    parameter int    SPRITE_H        = 64,
    parameter int    PIX_BITS        = 4,
    parameter int    COORD_W         = 10,
    parameter int    TRANSPARENT_IDX = 0,
    parameter int    HOLD_FRAMES     = 6,
    parameter string INIT_FILE       = "sprite_bank.mif",
    localparam int   POSE_W          = $clog2(NUM_POSES),
    localparam int   ADDR_W          = $clog2(NUM_POSES * SPRITE_W * SPRITE_H)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_start,
    input  logic [POSE_W-1:0]   pose_req,
    input  logic                flip,
    input  logic                pix_req,
    input  logic [COORD_W-1:0]  pix_x,
    input  logic [COORD_W-1:0]  pix_y,
    output logic [POSE_W-1:0]   pose_active,
    output logic                pix_valid,
    output logic [PIX_BITS-1:0] pix_index,
    output logic                pix_opaque
);

    localparam int XB    = $clog2(SPRITE_W);
    localparam int YB    = $clog2(SPRITE_H);
    localparam int DEPTH = NUM_POSES * SPRITE_W * SPRITE_H;
    localparam logic [PIX_BITS-1:0] T_IDX     = PIX_BITS'(TRANSPARENT_IDX);
    localparam logic [POSE_W:0]     POSE_LIM  = (POSE_W+1)'(NUM_POSES);

    (* ram_init_file = INIT_FILE *)
    logic [PIX_BITS-1:0] mem [0:DEPTH-1] = '{default: T_IDX};

    logic              pose_ok;
    logic              accept;
    logic [POSE_W-1:0] pose_eff;
    logic              in_box;
    logic [XB-1:0]     xm;
    logic [ADDR_W-1:0] addr;

    logic              v0;
    logic              in_box0;
    logic [ADDR_W-1:0] addr0;
    logic [PIX_BITS-1:0] rd_word;

    assign pose_ok = {1'b0, pose_req} < POSE_LIM;

`ifdef SPRITE_POSE_HOLD_EN
    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    logic [HOLD_W-1:0] hold_cnt;
    logic              pose_change;

    assign pose_change = pose_req != pose_active;
    // A repeat of the current pose is always "accepted" but must not restart the hold window.
    assign accept = frame_start && pose_ok &&
                    (!pose_change || hold_cnt == '0 || HOLD_FRAMES == 0);

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (frame_start) begin
            if (accept && pose_change && HOLD_FRAMES > 0)
                hold_cnt <= HOLD_W'(HOLD_FRAMES - 1);
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
        end
    end
`else
    assign accept = frame_start && pose_ok;
`endif

    // A request in the same cycle as an accepted frame_start already sees the new pose.
    assign pose_eff = accept ? pose_req : pose_active;
    assign in_box   = (pix_x < COORD_W'(SPRITE_W)) && (pix_y < COORD_W'(SPRITE_H));
    assign xm       = flip ? ~pix_x[XB-1:0] : pix_x[XB-1:0];
    // Low coordinate bits keep out-of-box requests inside the current pose's region.
    assign addr     = ADDR_W'({pose_eff, pix_y[YB-1:0], xm});
    assign rd_word  = mem[addr0];

    always_ff @(posedge clock) begin
        if (reset) begin
            pose_active <= '0;
        end else if (accept) begin
            pose_active <= pose_req;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v0      <= 1'b0;
            in_box0 <= 1'b0;
            addr0   <= '0;
        end else begin
            v0      <= pix_req;
            in_box0 <= in_box;
            addr0   <= addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_valid  <= 1'b0;
            pix_index  <= T_IDX;
            pix_opaque <= 1'b0;
        end else begin
            pix_valid <= v0;
            if (v0) begin
                pix_index  <= in_box0 ? rd_word : T_IDX;
                pix_opaque <= in_box0 && (rd_word != T_IDX);
            end
        end
    end

endmodule
